// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block and its downstream drain stage.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_BUF_DEPTH = 2;

    typedef logic [DEF_WIDTH-1:0] data_t;

    // Pointer width for a power-of-two buffer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned DEF_PTR_W = ptr_width(DEF_BUF_DEPTH);

endpackage

// File: rtl/drain_buf.sv
// Small circular buffer holding words captured from the FIFO until the sink takes them.
module drain_buf
    import fifo_pkg::*;
#(
    parameter int unsigned width = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);

    logic [width-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointer advance; power-of-two depth lets them wrap without compare logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the entries are reset because out_data must read 0 out of reset;
            // with only a handful of entries this costs nothing and keeps dout defined.
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            if (wr) mem_q[wr_ptr_q] <= din;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign dout = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_drain.sv
// Pops words from the upstream FIFO, absorbs its one-cycle read latency in a
// local buffer and presents them on a valid/ready stream.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int unsigned width     = DEF_WIDTH,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_dataout,
    output logic             fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [CNT_W-1:0] delivered,
    output logic             idle
);

    // One extra bit so occupancy can hold the full value BUF_DEPTH.
    localparam int unsigned OCC_W = ptr_width(BUF_DEPTH) + 1;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             infl_q, infl_d;
    logic [CNT_W-1:0] delivered_q, delivered_d;
    logic             acc;

    assign out_valid = (occ_q != '0);
    assign acc       = out_valid & out_ready;

    // Credit check and next-state: occ_d is the number of words still owed to
    // the sink after this cycle, so a pop is only issued if its word will fit.
    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        occ_d       = occ_q + OCC_W'(infl_q) - OCC_W'(acc);
        // Gated by rst so no pop escapes while the block is held in reset.
        fifo_pop    = rst & drain_en & ~fifo_empty & (occ_d < OCC_W'(BUF_DEPTH));
        infl_d      = fifo_pop;
        delivered_d = delivered_q + CNT_W'(acc);
    end

    // Bookkeeping registers: occupancy, in-flight flag and delivered count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q       <= '0;
            infl_q      <= 1'b0;
            delivered_q <= '0;
        end else begin
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            delivered_q <= delivered_d;
        end
    end

    // The word popped last cycle is on fifo_dataout now; capture it.
    drain_buf #(
        .width (width),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .wr   (infl_q),
        .rd   (acc),
        .din  (fifo_dataout),
        .dout (out_data)
    );

    assign delivered = delivered_q;
    assign idle      = (occ_q == '0) & ~infl_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: emulated upstream FIFO, a transaction-level
// reference model checked every cycle, and directed plus random scenarios.
module tb_fifo_drain;
    import fifo_pkg::*;

    localparam int BD = 2;

    logic  clk = 1'b0, rst = 1'b1, drain_en = 1'b0, fifo_empty = 1'b1, out_ready = 1'b0;
    data_t fifo_dataout = '0;
    logic  fifo_pop, out_valid, idle, fifo_pop_w, out_valid_w, idle_w;
    data_t out_data, out_data_w;
    logic [15:0] delivered;
    logic [3:0]  delivered_w;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    fifo_drain #(.width(8), .BUF_DEPTH(BD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .drain_en(drain_en), .fifo_empty(fifo_empty),
        .fifo_dataout(fifo_dataout), .fifo_pop(fifo_pop), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .delivered(delivered), .idle(idle)
    );

    fifo_drain #(.width(8), .BUF_DEPTH(BD), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .drain_en(drain_en), .fifo_empty(fifo_empty),
        .fifo_dataout(fifo_dataout), .fifo_pop(fifo_pop_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .delivered(delivered_w), .idle(idle_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO contents (environment) and the model's own copy of the same words.
    data_t env_q[$];
    data_t mdl_q[$];

    task automatic load(input data_t w);
        env_q.push_back(w);
        mdl_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words popped but not yet delivered, each visible to the
    // sink two cycles after the cycle in which it was popped.
    typedef struct {
        data_t data;
        int    avail;
    } item_t;

    item_t items[$];
    int    cyc = 0;
    int    mdl_delivered = 0;
    bit    exp_valid, exp_acc, exp_pop;
    logic  pop_seen = 1'b0;

    // Compare process: predict outputs from model state and current inputs.
    always @(negedge clk) begin
        if (!rst) begin
            exp_valid = 1'b0;
            exp_acc   = 1'b0;
            exp_pop   = 1'b0;
            check("rst_pop", fifo_pop, 0);
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_delivered", delivered, 0);
            check("rst_delivered_w", delivered_w, 0);
            check("rst_idle", idle, 1);
        end else begin
            exp_valid = (items.size() > 0) && (items[0].avail <= cyc);
            exp_acc   = exp_valid && out_ready;
            exp_pop   = drain_en && !fifo_empty && ((items.size() - int'(exp_acc)) < BD);
            check("pop", fifo_pop, exp_pop);
            check("valid", out_valid, exp_valid);
            if (exp_valid) check("data", out_data, items[0].data);
            check("delivered", delivered, mdl_delivered & 32'hFFFF);
            check("idle", idle, items.size() == 0);
            check("w_pop", fifo_pop_w, exp_pop);
            check("w_valid", out_valid_w, exp_valid);
            if (exp_valid) check("w_data", out_data_w, items[0].data);
            check("w_delivered", delivered_w, mdl_delivered & 32'hF);
            check("w_idle", idle_w, items.size() == 0);
            check("invariant", (32'(dut.occ_q) + 32'(dut.infl_q)) <= BD, 1);
        end
        pop_seen = fifo_pop;
    end

    // Model update at the edge, then the emulated FIFO answers the DUT's pop.
    always @(posedge clk) begin
        if (!rst) begin
            items.delete();
            mdl_delivered = 0;
        end else begin
            if (exp_acc) begin
                void'(items.pop_front());
                mdl_delivered++;
            end
            if (exp_pop) begin
                item_t it;
                it.data  = (mdl_q.size() > 0) ? mdl_q.pop_front() : 8'hEE;
                it.avail = cyc + 2;
                items.push_back(it);
            end
        end
        cyc++;
        #1;
        if (pop_seen && env_q.size() > 0) fifo_dataout = env_q.pop_front();
        fifo_empty = (env_q.size() == 0);
    end

    int    pops, first_pop, first_val, last_val, t_acc, found;
    data_t got[$];
    logic  idle_hist[8];

    initial begin
        // Reset held 10 cycles with the FIFO non-empty and popping enabled.
        #1 rst = 1'b0;
        drain_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) load(data_t'(i));
        repeat (10) begin
            @(negedge clk);
            check("reset_hold_pop", fifo_pop, 0);
            check("reset_hold_idle", idle, 1);
        end
        next_cycle();
        rst = 1'b1;

        // Streaming 0x01..0x10 with the sink always ready.
        first_pop = -1; first_val = -1; last_val = -1; got.delete();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (fifo_pop && first_pop < 0) first_pop = i;
            if (out_valid) begin
                if (first_val < 0) first_val = i;
                last_val = i;
                got.push_back(out_data);
            end
        end
        check("stream_first_pop", first_pop, 0);
        check("stream_latency", first_val - first_pop, 2);
        check("stream_run", last_val - first_val + 1, 16);
        check("stream_count", got.size(), 16);
        for (int k = 0; k < 16; k++) if (k < got.size()) check("stream_data", got[k], k + 1);
        check("stream_delivered", delivered, 16);
        check("stream_delivered_w", delivered_w, 0);

        // Back-pressure: sink stalled with 5 words waiting.
        next_cycle();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) load(data_t'(i));
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_pop) pops++;
        end
        check("bp_pops", pops, 2);
        check("bp_occ", dut.occ_q, 2);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", out_data, 8'h01);
        end
        next_cycle();
        out_ready = 1'b1;
        pops = 0; got.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_pop) pops++;
            if (out_valid && out_ready) got.push_back(out_data);
        end
        check("bp_late_pops", pops, 3);
        check("bp_count", got.size(), 5);
        for (int k = 0; k < 5; k++) if (k < got.size()) check("bp_data", got[k], k + 1);

        // Empty boundary: a single word, then the FIFO runs dry.
        next_cycle();
        load(8'hA5);
        pops = 0; got.delete(); t_acc = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_pop) pops++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                t_acc = i;
            end
            idle_hist[i] = idle;
        end
        check("empty_pops", pops, 1);
        check("empty_xfers", got.size(), 1);
        if (got.size() > 0) check("empty_data", got[0], 8'hA5);
        check("empty_xfer_slot", t_acc, 2);
        if (t_acc >= 0 && t_acc < 6) begin
            check("empty_busy", idle_hist[t_acc], 0);
            check("empty_idle", idle_hist[t_acc + 2], 1);
        end

        // drain_en drop right after a pop: the in-flight word still arrives.
        next_cycle();
        for (int i = 0; i < 4; i++) load(data_t'(8'h31 + i));
        found = 0;
        for (int i = 0; i < 5 && found == 0; i++) begin
            @(negedge clk);
            if (fifo_pop) found = 1;
        end
        check("drop_first_pop", found, 1);
        next_cycle();
        drain_en = 1'b0;
        pops = 0; got.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_pop) pops++;
            if (out_valid && out_ready) got.push_back(out_data);
        end
        check("drop_pops", pops, 0);
        check("drop_count", got.size(), 1);
        if (got.size() > 0) check("drop_data", got[0], 8'h31);
        next_cycle();
        drain_en = 1'b1;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out_data);
        end
        check("resume_count", got.size(), 3);
        for (int k = 0; k < 3; k++) if (k < got.size()) check("resume_data", got[k], 8'h32 + k);

        // Random traffic, ready and enable; the compare process checks every cycle.
        next_cycle();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) load(data_t'($urandom));
            drain_en  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            next_cycle();
        end
        drain_en  = 1'b1;
        out_ready = 1'b1;
        repeat (200) next_cycle();
        @(negedge clk);
        check("rand_idle", idle, 1);
        check("rand_src_empty", fifo_empty, 1);

        // Async reset between edges while a word is in flight.
        next_cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(data_t'(8'h41 + i));
        found = 0;
        for (int i = 0; i < 5 && found == 0; i++) begin
            @(negedge clk);
            if (fifo_pop) found = 1;
        end
        check("arst_first_pop", found, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("arst_pre_infl", dut.infl_q, 1);
        check("arst_pre_valid", out_valid, 1);
        check("arst_pre_data", out_data, 8'h41);
        rst = 1'b0;
        env_q.delete();
        mdl_q.delete();
        fifo_empty = 1'b1;
        #1;
        check("arst_pop", fifo_pop, 0);
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_delivered", delivered, 0);
        check("arst_delivered_w", delivered_w, 0);
        check("arst_idle", idle, 1);
        check("arst_occ", dut.occ_q, 0);
        check("arst_infl", dut.infl_q, 0);
        next_cycle();
        rst = 1'b1;

        // Counter wrap: 17 transfers on the 4-bit counter leave it at 1.
        drain_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) load(data_t'(8'h50 + i));
        repeat (25) @(negedge clk);
        check("wrap_delivered_w", delivered_w, 1);
        check("wrap_delivered", delivered, 17);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Downstream consumer of the `fifo` block. Pops words from the FIFO and accounts for the FIFO's one-cycle read latency. Holds popped words in a small local buffer and presents them on a valid/ready stream to the next stage. Sustains one word per cycle when the sink is always ready, never pops when the FIFO is empty, and never loses a popped word.

## Interface
- `width`, 8: data word width; must match the upstream `fifo`.
- `BUF_DEPTH`, 2: local buffer entries; minimum 2, power of two.
- `CNT_W`, 16: width of the delivered-word counter.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  reset, asynchronous and active-low: asserting it (0) clears all state immediately, independent of `clk`.
- `drain_en`  in  1  1 = allowed to issue pops; 0 = stop popping, but still deliver words already in flight or buffered.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dataout`  in  `width`  FIFO `dataout`; valid in the cycle after a pop.
- `fifo_pop`  out  1  FIFO `pop` strobe.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  `width`  head-of-buffer word.
- `delivered`  out  `CNT_W`  count of words transferred on the output.
- `idle`  out  1  nothing in flight and buffer empty.

## Operation
- State:
  - `occ`: buffer occupancy, 0..`BUF_DEPTH`.
  - `infl`: pops issued whose data has not yet been captured, 0..1.
  - `wr_ptr` / `rd_ptr`: buffer pointers of width log2(`BUF_DEPTH`); they wrap naturally.
- Accept: `acc = out_valid & out_ready`.
- Pop decision, combinational and registered-free: `fifo_pop = drain_en & ~fifo_empty & ((occ + infl - acc) < BUF_DEPTH)`.
- Capture: if `infl` = 1, write `fifo_dataout` into `buf[wr_ptr]` and increment `wr_ptr`.
- Next `infl` = `fifo_pop`.
- Next `occ` = `occ + infl - acc`. Simultaneous capture and accept leaves `occ` unchanged.
- `out_valid = (occ != 0)`.
- `out_data = buf[rd_ptr]`.
- On `acc`, increment `rd_ptr`.
- `delivered` increments by 1 on each `acc` and wraps modulo 2^`CNT_W` with no saturation.
- `idle = (occ == 0) & (infl == 0)`.
- Deasserting `drain_en` never cancels an outstanding `infl`; that word is still captured and delivered.
- Invariant: `occ + infl` ≤ `BUF_DEPTH` at every edge. The bench asserts it.
- Sink stall: the buffer fills, then `fifo_pop` drops; the FIFO retains its words.

## Timing
- Reset values (rst = 0):
  - `fifo_pop` = 0, `out_valid` = 0, `out_data` = 0, `delivered` = 0, `idle` = 1.
  - Pointers, `occ` and `infl` = 0; buffer contents = 0.
- Latency: `fifo_pop` high in cycle n → `fifo_dataout` valid in n+1 → captured at the end of n+1 → `out_valid` high in n+2.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, `fifo_pop` and `acc` are high every cycle after the 2-cycle fill.
- `out_valid`/`out_data` handshake rules:
  - Once asserted, `out_valid` stays high and `out_data` stays stable until `acc`.
  - `out_valid` does not depend combinationally on `out_ready`.
- `fifo_pop` does depend combinationally on `out_ready` (through `acc`). The sink must drive `out_ready` from registers.
- Reset mid-operation: all state clears asynchronously, including any buffered or in-flight word. Those words are dropped; the FIFO is reset alongside.
- Release of `rst` is synchronised externally. The first pop can occur in the first cycle after release.

## Structure
- Package `fifo_pkg`: `width` default, `data_t` typedef (`logic [width-1:0]`), `BUF_DEPTH` default, and a `clog2`-based pointer-width constant. Shared with `fifo` and the bench.
- Sub-module `drain_buf`: the `BUF_DEPTH`-entry register array with write/read pointers, exposing `wr`, `rd`, `din`, `dout`.
- Top level: pop/credit logic, `occ`/`infl` bookkeeping and the `delivered` counter.

## Test plan
- Reset: hold rst = 0 for 10 cycles while driving `fifo_empty` = 0 → `fifo_pop` = 0, `out_valid` = 0, `delivered` = 0, `idle` = 1 throughout.
- Streaming: FIFO preloaded with 0x01..0x10, `out_ready` = 1 → out_data sequence 0x01..0x10 with `out_valid` high 16 consecutive cycles starting 2 cycles after the first pop; `delivered` = 16.
- Back-pressure: `out_ready` = 0 with the FIFO holding 5 words → exactly 2 pops, `occ` = 2, `out_data` = 0x01 stable. Then `out_ready` = 1 → remaining words 0x02..0x05 in order, none lost or duplicated.
- Empty boundary: FIFO supplies 1 word, then `fifo_empty` = 1 → exactly one pop, one transfer, `idle` = 1 two cycles after the transfer.
- `drain_en` drop: deassert `drain_en` in the same cycle as a pop → that word is still delivered and no further pops occur. Reasserting resumes with the next word.
- Wrap and async reset:
  - With `CNT_W` = 4, transfer 17 words → `delivered` = 1.
  - Assert rst between edges while `infl` = 1 → outputs return to their reset values before the next edge.
